optical_combiner_nch: RTL and testbench
=======================================

Name: optical_combiner_nch

Overview:
- Parametrised N-channel successor to the two-input optical OR gate.
- Each input channel carries a multi-bit photodetector intensity sample instead of a single light/no-light bit.
- Per-channel hysteresis thresholding converts each sample to a lit/dark state; the lit states are then combined in a selectable logic mode (OR/AND/XOR/MAJORITY).
- Also reports the attenuated, saturated combined optical power of a passive N:1 coupler. Sits between the detector front-end and downstream optical-logic consumers, using valid/ready handshakes on both sides.

Parameters:
- N_CH, 4, number of optical input channels (2..16)
- W, 8, intensity sample width in bits
- ATTEN_SHIFT, 1, coupler loss model: summed intensity is right-shifted by this amount (0..4)

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input sample vector valid
- in_ready  out  1  block can accept a sample vector
- in_intensity  in  N_CH*W  channel k at bits [k*W +: W], unsigned
- thr_on  in  W  dark->lit threshold
- thr_off  in  W  lit->dark threshold
- mode  in  2  0=OR, 1=AND, 2=XOR (parity), 3=MAJORITY
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_bit  out  1  combined logical optical output
- out_lit  out  N_CH  per-channel lit state belonging to this result
- out_intensity  out  W  attenuated combined intensity, saturated
- out_sat  out  1  out_intensity was clipped

Behaviour:
- Clock and reset: single clock domain, clk. Reset is asynchronous and active-low on rst_n.
- Reset values: out_valid=0, out_bit=0, out_lit=0, out_intensity=0, out_sat=0, all channel states dark, stage-1 valid=0.
- Pipeline structure: two stages, S1 and S2 (the output register).
  - advance = !out_valid || out_ready
  - in_ready = advance; this is combinational and depends on out_ready.
  - On advance, S1 loads the accepted input (a bubble if in_valid=0), and S2 loads S1.
  - When !advance, both stages hold all contents.
- Latency: exactly 2 clk edges from an accepted input to out_valid=1, assuming no stall. Full throughput is one vector per cycle.
- Hysteresis, per channel, evaluated only on an accepted sample:
  - Effective off threshold: toff = min(thr_off, thr_on).
  - A dark channel with I >= thr_on becomes lit.
  - A lit channel with I < toff becomes dark.
  - Otherwise the channel keeps its state.
  - State changes only on accepted samples; bubbles and stalls never change it.
- The new channel state computed from each sample is the one reported in out_lit for that sample.
- Threshold and mode sampling: thr_on, thr_off and mode are sampled together with the accepted vector and carried with it through the pipeline. A mid-stream mode change applies from the next accepted vector.
- Combine modes, applied over the N_CH lit bits L:
  - OR: out_bit = |L
  - AND: out_bit = &L
  - XOR: out_bit = ^L
  - MAJORITY: out_bit = (popcount(L)*2 > N_CH); ties give 0.
- Intensity path:
  - sum = Σ I_k, computed at width W+clog2(N_CH) with no overflow.
  - att = sum >> ATTEN_SHIFT
  - If att > 2^W-1, then out_intensity = 2^W-1 and out_sat = 1; otherwise out_intensity = att and out_sat = 0.
- Output hold: out_* stays stable while out_valid=1 and out_ready=0.
- Reset mid-operation: in-flight vectors are discarded and hysteresis states return to dark immediately (asynchronously).

Decomposition:
- Package optical_pkg:
  - optical_mode_e enum: OPT_OR, OPT_AND, OPT_XOR, OPT_MAJ.
  - Function clog2-based sum width.
  - Saturating-clip function.
- Sub-module optical_hyst_detector, instantiated N_CH times:
  - Inputs: clk, rst_n, en (accept), sample, thr_on, toff.
  - Outputs: registered lit state and next lit state.

Test Plan:
- Reset and basic OR, defaults, ATTEN_SHIFT=1, thr_on=100, thr_off=50, mode=0, out_ready=1:
  - Release reset; send {0,0,0,120}.
  - Two cycles later: out_valid=1, out_lit=4'b0001, out_bit=1, out_intensity=60, out_sat=0.
- Hysteresis on channel 0, sequence 120, 70, 40, 70:
  - Required out_lit[0] = 1, 1, 0, 0.
  - Misconfigured thresholds thr_off=150, thr_on=100: 120 gives lit, then 90 gives dark, because toff is clamped to 100.
- Modes, using L=4'b0111 (channels 0..2 at 200, channel 3 at 0):
  - OR→1, AND→0, XOR→1, MAJ→1.
  - L=4'b0011 with MAJ→0 (tie).
- Saturation: all channels 255 with ATTEN_SHIFT=1 → sum 1020, att 510 → out_intensity=255, out_sat=1.
- Backpressure:
  - Stream 5 vectors back-to-back; hold out_ready=0 for 3 cycles after the first output.
  - in_ready drops, outputs stay stable, no vector is lost or duplicated, order is preserved, and hysteresis does not advance during the stall.
- Asynchronous reset mid-stream:
  - Assert rst_n=0 between edges while out_valid=1 with lit states set.
  - All outputs clear immediately.
  - After release, first output appears 2 cycles after the first accepted input, with hysteresis restarting from dark.

Source files
------------

// File: rtl/optical_combiner_nch_pkg.sv
// Shared types and helpers for the N-channel optical combiner:
// combine-mode enum, sum-width calculation and the saturating clip.
package optical_pkg;

    typedef enum logic [1:0] {
        OPT_OR  = 2'd0,
        OPT_AND = 2'd1,
        OPT_XOR = 2'd2,
        OPT_MAJ = 2'd3
    } optical_mode_e;

    typedef struct packed {
        logic        sat;
        logic [31:0] val;
    } clip_t;

    // Width that holds the sum of n_ch samples of w bits without overflow.
    function automatic int unsigned sum_width(input int unsigned n_ch, input int unsigned w);
        return w + $clog2(n_ch);
    endfunction

    // Clip v to the largest w-bit value, flagging when clipping occurred.
    function automatic clip_t sat_clip(input logic [31:0] v, input int unsigned w);
        clip_t       r;
        logic [31:0] max_v;
        max_v = (32'd1 << w) - 32'd1;
        if (v > max_v) begin
            r.sat = 1'b1;
            r.val = max_v;
        end else begin
            r.sat = 1'b0;
            r.val = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/optical_combiner_nch_hyst.sv
// Per-channel hysteresis detector: turns an intensity sample into a lit/dark
// state that only moves when a sample is accepted.
module optical_hyst_detector #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] sample_i,
    input  logic [W-1:0] thr_on_i,
    input  logic [W-1:0] toff_i,
    output logic         lit_o,
    output logic         lit_next_o
);

    logic lit_q;

    always_comb begin
        lit_next_o = lit_q;
        if (!lit_q && (sample_i >= thr_on_i)) begin
            lit_next_o = 1'b1;
        end else if (lit_q && (sample_i < toff_i)) begin
            lit_next_o = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lit_q <= 1'b0;
        end else if (en_i) begin
            lit_q <= lit_next_o;
        end
    end

    assign lit_o = lit_q;

endmodule

// File: rtl/optical_combiner_nch.sv
// N-channel optical combiner: hysteresis per channel, selectable logic
// combine of the lit states, and attenuated/saturated coupler power.
module optical_combiner_nch
    import optical_pkg::*;
#(
    parameter int unsigned N_CH        = 4,
    parameter int unsigned W           = 8,
    parameter int unsigned ATTEN_SHIFT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_CH*W-1:0] in_intensity,
    input  logic [W-1:0]      thr_on,
    input  logic [W-1:0]      thr_off,
    input  logic [1:0]        mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_bit,
    output logic [N_CH-1:0]   out_lit,
    output logic [W-1:0]      out_intensity,
    output logic              out_sat
);

    localparam int unsigned SUM_W = sum_width(N_CH, W);

    logic              advance_c;
    logic              accept_c;
    logic [W-1:0]      toff_c;
    logic [N_CH-1:0]   lit_state;
    logic [N_CH-1:0]   lit_next_c;
    logic [SUM_W-1:0]  sum_c;
    logic [SUM_W-1:0]  att_c;
    clip_t             clip_c;

    logic              s1_valid_q;
    logic              s1_bit_q;
    logic [SUM_W-1:0]  s1_sum_q;

    logic              out_valid_q;
    logic              out_bit_q;
    logic [N_CH-1:0]   out_lit_q;
    logic [W-1:0]      out_intensity_q;
    logic              out_sat_q;

    function automatic logic combine(input logic [N_CH-1:0] l, input optical_mode_e m);
        int unsigned pc;
        logic        r;
        pc = 0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            pc = pc + 32'(l[k]);
        end
        case (m)
            OPT_OR:  r = |l;
            OPT_AND: r = &l;
            OPT_XOR: r = ^l;
            OPT_MAJ: r = ((pc * 2) > N_CH);
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    assign advance_c = !out_valid_q || out_ready;
    assign accept_c  = in_valid && advance_c;
    assign in_ready  = advance_c;
    assign toff_c    = (thr_off < thr_on) ? thr_off : thr_on;

    // The detector register doubles as the S1 lit state of the vector in flight.
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        optical_hyst_detector #(.W(W)) u_hyst (
            .clk        (clk),
            .rst_n      (rst_n),
            .en_i       (accept_c),
            .sample_i   (in_intensity[k*W +: W]),
            .thr_on_i   (thr_on),
            .toff_i     (toff_c),
            .lit_o      (lit_state[k]),
            .lit_next_o (lit_next_c[k])
        );
    end

    always_comb begin
        sum_c = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            sum_c = sum_c + SUM_W'(in_intensity[k*W +: W]);
        end
    end

    assign att_c  = s1_sum_q >> ATTEN_SHIFT;
    assign clip_c = sat_clip(32'(att_c), W);

    // Stage 1: combined bit and coupler sum of the accepted vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_bit_q   <= 1'b0;
            s1_sum_q   <= '0;
        end else if (advance_c) begin
            s1_valid_q <= in_valid;
            if (accept_c) begin
                s1_bit_q <= combine(lit_next_c, optical_mode_e'(mode));
                s1_sum_q <= sum_c;
            end
        end
    end

    // Stage 2: output register, held while downstream stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q     <= 1'b0;
            out_bit_q       <= 1'b0;
            out_lit_q       <= '0;
            out_intensity_q <= '0;
            out_sat_q       <= 1'b0;
        end else if (advance_c) begin
            out_valid_q     <= s1_valid_q;
            out_bit_q       <= s1_bit_q;
            out_lit_q       <= lit_state;
            out_intensity_q <= W'(clip_c.val);
            out_sat_q       <= clip_c.sat;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_bit       = out_bit_q;
    assign out_lit       = out_lit_q;
    assign out_intensity = out_intensity_q;
    assign out_sat       = out_sat_q;

endmodule

// File: tb/tb_optical_combiner_nch.sv
// Directed bench for optical_combiner_nch with a behavioural model feeding
// an expected-result queue that is checked as results leave the DUT.
module tb_optical_combiner_nch;

    localparam int unsigned N_CH = 4;
    localparam int unsigned W    = 8;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N_CH*W-1:0] in_intensity;
    logic [W-1:0]      thr_on;
    logic [W-1:0]      thr_off;
    logic [1:0]        mode;
    logic              out_valid;
    logic              out_ready;
    logic              out_bit;
    logic [N_CH-1:0]   out_lit;
    logic [W-1:0]      out_intensity;
    logic              out_sat;

    typedef struct {
        logic            bit_v;
        logic [N_CH-1:0] lit;
        logic [W-1:0]    inten;
        logic            sat;
    } exp_t;

    exp_t            sb[$];
    logic [N_CH-1:0] mdl_lit;
    int              n_assert = 0;
    int              n_fail   = 0;
    logic            last_ov;
    logic            last_acc;

    optical_combiner_nch #(.N_CH(N_CH), .W(W), .ATTEN_SHIFT(1)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_intensity  (in_intensity),
        .thr_on        (thr_on),
        .thr_off       (thr_off),
        .mode          (mode),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_bit       (out_bit),
        .out_lit       (out_lit),
        .out_intensity (out_intensity),
        .out_sat       (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_vec(input int a0, input int a1, input int a2, input int a3);
        in_intensity = {8'(a3), 8'(a2), 8'(a1), 8'(a0)};
    endtask

    // Behavioural model of one accepted vector.
    task automatic model_push();
        exp_t     e;
        int       sum;
        int       att;
        int       pc;
        int       s;
        int       toff;
        toff = (thr_off < thr_on) ? int'(thr_off) : int'(thr_on);
        sum  = 0;
        pc   = 0;
        for (int k = 0; k < N_CH; k++) begin
            s = int'(in_intensity[k*W +: W]);
            if (!mdl_lit[k] && s >= int'(thr_on)) mdl_lit[k] = 1'b1;
            else if (mdl_lit[k] && s < toff)      mdl_lit[k] = 1'b0;
            if (mdl_lit[k]) pc++;
            sum += s;
        end
        case (mode)
            2'd0:    e.bit_v = (pc > 0);
            2'd1:    e.bit_v = (pc == N_CH);
            2'd2:    e.bit_v = pc[0];
            default: e.bit_v = (pc * 2 > N_CH);
        endcase
        e.lit = mdl_lit;
        att   = sum >> 1;
        if (att > 255) begin
            e.inten = 8'd255;
            e.sat   = 1'b1;
        end else begin
            e.inten = 8'(att);
            e.sat   = 1'b0;
        end
        sb.push_back(e);
    endtask

    // One clock: check outputs and log accepts mid-cycle, then step past the edge.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        last_ov  = out_valid;
        last_acc = in_valid && in_ready;
        if (out_valid === 1'b1) begin
            if (!out_ready) chk("in_ready_stall", 32'(in_ready), 32'd0);
            if (sb.size() == 0) begin
                chk("unexpected_output", 32'd1, 32'd0);
            end else begin
                e = sb[0];
                chk("out_bit", 32'(out_bit), 32'(e.bit_v));
                chk("out_lit", 32'(out_lit), 32'(e.lit));
                chk("out_intensity", 32'(out_intensity), 32'(e.inten));
                chk("out_sat", 32'(out_sat), 32'(e.sat));
                if (out_ready) void'(sb.pop_front());
            end
        end
        if (last_acc) model_push();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int a0, input int a1, input int a2, input int a3);
        set_vec(a0, a1, a2, a3);
        in_valid = 1'b1;
        cycle();
        chk("send_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic flush();
        in_valid = 1'b0;
        for (int i = 0; i < 12 && sb.size() > 0; i++) cycle();
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        int ch0_seq[5];
        int idx;
        int stall;
        bit started;
        ch0_seq = '{120, 40, 120, 40, 120};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        thr_on    = 8'd100;
        thr_off   = 8'd50;
        mode      = 2'd0;
        mdl_lit   = '0;
        set_vec(0, 0, 0, 0);
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bit", 32'(out_bit), 32'd0);
        chk("rst_out_lit", 32'(out_lit), 32'd0);
        chk("rst_out_intensity", 32'(out_intensity), 32'd0);
        chk("rst_out_sat", 32'(out_sat), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Basic OR with two-edge latency.
        send(120, 0, 0, 0);
        in_valid = 1'b0;
        cycle();
        chk("lat_basic_s1", 32'(last_ov), 32'd0);
        cycle();
        chk("lat_basic_s2", 32'(last_ov), 32'd1);
        flush();

        // Hysteresis on channel 0.
        send(120, 0, 0, 0);
        send(70, 0, 0, 0);
        send(40, 0, 0, 0);
        send(70, 0, 0, 0);
        flush();

        // Off threshold above on threshold clamps to thr_on.
        thr_off = 8'd150;
        send(120, 0, 0, 0);
        send(90, 0, 0, 0);
        flush();
        thr_off = 8'd50;

        // Combine modes.
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            send(200, 200, 200, 0);
        end
        mode = 2'd3;
        send(200, 200, 0, 0);
        flush();

        // Saturation.
        mode = 2'd0;
        send(255, 255, 255, 255);
        flush();

        // Back-to-back stream with a three-cycle downstream stall.
        idx     = 0;
        stall   = 0;
        started = 1'b0;
        for (int c = 0; c < 40 && (idx < 5 || sb.size() > 0); c++) begin
            in_valid = (idx < 5);
            if (idx < 5) set_vec(ch0_seq[idx], int'($urandom_range(0, 255)),
                                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
            out_ready = (stall == 0);
            cycle();
            if (stall > 0) chk("stall_hold_valid", 32'(last_ov), 32'd1);
            if (last_acc) idx++;
            if (stall > 0) stall--;
            else if (!started && last_ov) begin
                started = 1'b1;
                stall   = 3;
            end
        end
        out_ready = 1'b1;
        chk("stream_all_sent", 32'(idx), 32'd5);
        flush();

        // Asynchronous reset with a held valid result and lit channels.
        send(200, 200, 200, 200);
        in_valid  = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < 6 && !last_ov; i++) cycle();
        #2;
        chk("pre_reset_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(out_valid), 32'd0);
        chk("async_rst_lit", 32'(out_lit), 32'd0);
        chk("async_rst_bit", 32'(out_bit), 32'd0);
        chk("async_rst_intensity", 32'(out_intensity), 32'd0);
        chk("async_rst_sat", 32'(out_sat), 32'd0);
        sb.delete();
        mdl_lit = '0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        send(70, 70, 70, 70);
        in_valid = 1'b0;
        cycle();
        chk("lat_post_rst_s1", 32'(last_ov), 32'd0);
        cycle();
        chk("lat_post_rst_s2", 32'(last_ov), 32'd1);
        flush();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
